// File: rtl/nv_ram_rwsp_80x14_core.sv
// nv_ram_rwsp_80x14_core
// 80-entry x 14-bit RAM with one write port and one read port. Reads go
// through two registers: a read stage (loaded by re) and an output stage
// (loaded by ore). The consumer prefetches with re and pops with ore, so the
// two stages shift like a two-deep pipeline.
// No handshake: every enable acts on the rising edge where it is high.

module nv_ram_rwsp_80x14_core #(
    parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pwrbus_ram_pd,
    input  logic [6:0]  wa,
    input  logic        we,
    input  logic [13:0] di,
    input  logic [6:0]  ra,
    input  logic        re,
    input  logic        ore,
    output logic [13:0] dout
);

    localparam logic [6:0] DEPTH = 7'd80;

    logic [13:0] mem [0:79];
    logic [13:0] rd_q;
    logic [13:0] dout_q;
    logic        wa_ok;
    logic        ra_ok;

    // The power sideband has no functional effect on data or timing.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign wa_ok = (wa < DEPTH);
    assign ra_ok = (ra < DEPTH);

    // Array write; not reset, and still active while rst is high.
    always_ff @(posedge clk) begin
        if (we && wa_ok) begin
            mem[wa] <= di;
        end
    end

    // Read stage: sees the pre-write contents on a same-address collision;
    // out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 14'h0;
        end else if (re) begin
            rd_q <= ra_ok ? mem[ra] : 14'h0;
        end
    end

    // Output stage: moves the read stage to dout on each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= 14'h0;
        end else if (ore) begin
            dout_q <= rd_q;
        end
    end

    assign dout = dout_q;

`ifndef SYNTHESIS
    // Simulation-only misuse checks: contention and out-of-range access.
    always_ff @(posedge clk) begin
        if (!FORCE_CONTENTION_ASSERTION_RESET_ACTIVE) begin
            assert (!(re && we && (ra == wa)))
            else $error("nv_ram_rwsp_80x14_core: read/write contention at addr %0d", ra);
        end
        if (!rst) begin
            assert (!(we && !wa_ok))
            else $error("nv_ram_rwsp_80x14_core: write address %0d out of range", wa);
            assert (!(re && !ra_ok))
            else $error("nv_ram_rwsp_80x14_core: read address %0d out of range", ra);
        end
    end
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_80x14_core.sv
// Testbench for nv_ram_rwsp_80x14_core: a table of per-cycle vectors with the
// expected dout after each edge, plus a randomized pipelined burst.

module tb_nv_ram_rwsp_80x14_core;

    logic        clk;
    logic        rst;
    logic [31:0] pwrbus_ram_pd;
    logic [6:0]  wa;
    logic        we;
    logic [13:0] di;
    logic [6:0]  ra;
    logic        re;
    logic        ore;
    logic [13:0] dout;

    int tests_run;
    int tests_failed;

    logic [13:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        we;
        logic [6:0]  wa;
        logic [13:0] di;
        logic        re;
        logic [6:0]  ra;
        logic        ore;
        logic [13:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    nv_ram_rwsp_80x14_core #(
        .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .wa            (wa),
        .we            (we),
        .di            (di),
        .ra            (ra),
        .re            (re),
        .ore           (ore),
        .dout          (dout)
    );

    // Clock and idle inputs
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input int a_w,
                                input int d, input logic rd, input int a_r,
                                input logic o, input int e, input string n);
        vec_t v;
        v.rst  = r;
        v.we   = w;
        v.wa   = 7'(a_w);
        v.di   = 14'(d);
        v.re   = rd;
        v.ra   = 7'(a_r);
        v.ore  = o;
        v.exp  = 14'(e);
        v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: dout=%h expected=%h", name, act, expv);
        end
    endtask

    // Driver: apply one cycle of inputs at negedge, sample after the posedge.
    task automatic drive(input vec_t v);
        rst = v.rst; we = v.we; wa = v.wa; di = v.di;
        re = v.re; ra = v.ra; ore = v.ore;
        pwrbus_ram_pd = $urandom;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we = 1'b0; wa = '0; di = '0;
        re = 1'b0; ra = '0; ore = 1'b0;
    endtask

    initial begin
        logic [6:0]  addrs [8];
        logic [13:0] datas [8];
        int          base;
        logic [13:0] popped;

        tests_run    = 0;
        tests_failed = 0;
        pwrbus_ram_pd = '0;
        idle_inputs();
        @(negedge clk);

        //        rst we  wa  di       re  ra  ore exp      name
        // Reset with re/ore active, then idle
        vecs.push_back(mk(1, 0, 0,  0,       1, 0,  1, 14'h0,   "reset_c1"));
        vecs.push_back(mk(1, 0, 0,  0,       1, 0,  1, 14'h0,   "reset_c2"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  0, 14'h0,   "reset_idle"));
        // Basic write then two-stage read
        vecs.push_back(mk(0, 1, 5,  14'h1A5, 0, 0,  0, 14'h0,   "basic_wr"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 5,  0, 14'h0,   "basic_re_only"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h1A5, "basic_ore"));
        // Streaming across the top of the address range
        vecs.push_back(mk(0, 1, 78, 14'h3001, 0, 0, 0, 14'h1A5, "stream_wr78"));
        vecs.push_back(mk(0, 1, 79, 14'h3002, 0, 0, 0, 14'h1A5, "stream_wr79"));
        vecs.push_back(mk(0, 1, 0,  14'h3003, 0, 0, 0, 14'h1A5, "stream_wr0"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 78, 0, 14'h1A5, "stream_re78"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 79, 1, 14'h3001, "stream_out0"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 0,  1, 14'h3002, "stream_out1"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h3003, "stream_out2"));
        // Output hold for 5 cycles, then pop the last read stage
        vecs.push_back(mk(0, 1, 20, 14'h0F0, 0, 0,  0, 14'h3003, "hold_wr"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 20, 0, 14'h3003, "hold_re"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h0F0, "hold_load"));
        vecs.push_back(mk(0, 1, 21, 14'h0AB, 0, 0,  0, 14'h0F0, "hold_c1"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 21, 0, 14'h0F0, "hold_c2"));
        vecs.push_back(mk(0, 1, 22, 14'h0CD, 0, 0,  0, 14'h0F0, "hold_c3"));
        vecs.push_back(mk(0, 1, 23, 14'h0EE, 1, 22, 0, 14'h0F0, "hold_c4"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  0, 14'h0F0, "hold_c5"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h0CD, "hold_release"));
        // Same-address collision: read sees old data, write completes
        vecs.push_back(mk(0, 1, 9,  14'h111, 0, 0,  0, 14'h0CD, "coll_init"));
        vecs.push_back(mk(0, 1, 9,  14'h222, 1, 9,  0, 14'h0CD, "coll_cycle"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h111, "coll_old"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 9,  0, 14'h111, "coll_reread"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h222, "coll_new"));
        // Reset preserves the array
        vecs.push_back(mk(0, 1, 40, 14'h2AA, 0, 0,  0, 14'h222, "rstkeep_wr"));
        vecs.push_back(mk(1, 0, 0,  0,       0, 0,  0, 14'h0,   "rstkeep_rst"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 40, 0, 14'h0,   "rstkeep_re"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h2AA, "rstkeep_ore"));
        // Reset discards in-flight read data
        vecs.push_back(mk(0, 0, 0,  0,       1, 5,  0, 14'h2AA, "flush_re"));
        vecs.push_back(mk(1, 0, 0,  0,       0, 0,  0, 14'h0,   "flush_rst"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h0,   "flush_ore"));
        // Write during reset lands; out-of-range write during reset is dropped
        vecs.push_back(mk(1, 1, 41, 14'h155, 0, 0,  0, 14'h0,   "rstwr_in"));
        vecs.push_back(mk(1, 1, 89, 14'h3FFF, 0, 0, 0, 14'h0,   "rstwr_oor"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 41, 0, 14'h0,   "rstwr_re41"));
        vecs.push_back(mk(0, 0, 0,  0,       1, 9,  1, 14'h155, "rstwr_out41"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h222, "oor_no_alias"));
        // Out-of-range read issued while reset is high yields zero
        vecs.push_back(mk(1, 0, 0,  0,       1, 100, 0, 14'h0,  "oor_rd_rst"));
        vecs.push_back(mk(0, 0, 0,  0,       0, 0,  1, 14'h0,   "oor_rd_ore"));

        // Table-driven pass through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i].exp);
            drive(vecs[i]);
            popped = exp_q.pop_front();
            check(vecs[i].name, dout, popped);
        end

        // Randomized burst: fill 8 consecutive addresses, then stream them out
        base = $urandom_range(0, 72);
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 7'(base + i);
            datas[i] = 14'($urandom_range(0, 16383));
            drive(mk(0, 1, int'(addrs[i]), int'(datas[i]), 0, 0, 0, 0, "burst_wr"));
        end
        for (int i = 0; i <= 8; i++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, (i < 8), (i < 8) ? int'(addrs[i]) : 0, (i > 0), 0, "burst_rd");
            if (i < 8) exp_q.push_back(datas[i]);
            drive(v);
            if (i > 0) begin
                popped = exp_q.pop_front();
                check($sformatf("burst_out%0d", i - 1), dout, popped);
            end
        end

        idle_inputs();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
